// File: rtl/pasta_job_scheduler.sv
// pasta_job_scheduler: arbitrates two requesters and sequences the per-block
// start/finish handshake with a keystream permutation core. Each accepted job
// walks its blocks, advancing the block counter and the plaintext address
// (17 words of 4 bytes per block).
// Optional watchdog on the core wait: define PASTA_SCHED_TIMEOUT_EN.
module pasta_job_scheduler (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  req_i,
    input  logic [15:0] nblk_i,
    input  logic [63:0] ptxt_base_i,
    output logic [1:0]  ack_o,
    output logic [1:0]  done_o,
    output logic        core_start_o,
    input  logic        core_busy_i,
    input  logic        core_finish_i,
    output logic [63:0] blk_ctr_o,
    output logic [31:0] ptxt_addr_o,
    output logic        owner_o,
    output logic        busy_o,
    output logic        timeout_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        NEXT  = 3'd4
    } state_t;

    localparam logic [31:0] BLK_BYTES = 32'd68;

    state_t      state;
    logic [7:0]  remaining;
    logic        last_grant;
    logic        sel;
    logic [7:0]  sel_nblk;
    logic [31:0] sel_base;

`ifdef PASTA_SCHED_TIMEOUT_EN
    logic [9:0]  wdog;
`else
    assign timeout_o = 1'b0;
`endif

    // Round-robin pick: a lone request wins, a tie goes to the one not served last.
    always_comb begin
        sel = 1'b0;
        if (req_i == 2'b10) begin
            sel = 1'b1;
        end else if (req_i == 2'b11) begin
            sel = ~last_grant;
        end
        sel_nblk = sel ? nblk_i[15:8] : nblk_i[7:0];
        sel_base = sel ? ptxt_base_i[63:32] : ptxt_base_i[31:0];
    end

    // Job sequencer: grant, per-block start/wait/advance, completion and abort.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            ack_o        <= 2'b00;
            done_o       <= 2'b00;
            core_start_o <= 1'b0;
            busy_o       <= 1'b0;
            owner_o      <= 1'b0;
            blk_ctr_o    <= 64'd0;
            ptxt_addr_o  <= 32'd0;
            remaining    <= 8'd0;
            last_grant   <= 1'b1;
`ifdef PASTA_SCHED_TIMEOUT_EN
            timeout_o    <= 1'b0;
            wdog         <= 10'd0;
`endif
        end else begin
            ack_o        <= 2'b00;
            done_o       <= 2'b00;
            core_start_o <= 1'b0;
`ifdef PASTA_SCHED_TIMEOUT_EN
            timeout_o    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req_i != 2'b00) begin
                        state       <= GRANT;
                        busy_o      <= 1'b1;
                        owner_o     <= sel;
                        remaining   <= sel_nblk;
                        ptxt_addr_o <= sel_base;
                        blk_ctr_o   <= 64'd0;
                        ack_o       <= 2'b01 << sel;
                        // An empty job is acknowledged and finished together.
                        if (sel_nblk == 8'd0) begin
                            done_o     <= 2'b01 << sel;
                            last_grant <= sel;
                        end
                    end
                end
                GRANT: begin
                    if (remaining == 8'd0) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        state <= START;
                    end
                end
                START: begin
                    if (!core_busy_i) begin
                        core_start_o <= 1'b1;
                        state        <= WAIT;
`ifdef PASTA_SCHED_TIMEOUT_EN
                        wdog         <= 10'd0;
`endif
                    end
                end
                WAIT: begin
                    if (core_finish_i) begin
                        state <= NEXT;
`ifdef PASTA_SCHED_TIMEOUT_EN
                    end else if (&wdog) begin
                        timeout_o  <= 1'b1;
                        done_o     <= 2'b01 << owner_o;
                        last_grant <= owner_o;
                        busy_o     <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        wdog <= wdog + 10'd1;
`endif
                    end
                end
                NEXT: begin
                    blk_ctr_o   <= blk_ctr_o + 64'd1;
                    ptxt_addr_o <= ptxt_addr_o + BLK_BYTES;
                    remaining   <= remaining - 8'd1;
                    if (remaining == 8'd1) begin
                        done_o     <= 2'b01 << owner_o;
                        last_grant <= owner_o;
                        busy_o     <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        state <= START;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pasta_job_scheduler.sv
// Scoreboard bench for pasta_job_scheduler: the driver predicts each job's
// acknowledge, per-block (owner, counter, address) starts and completion from
// the arbitration rules, and a monitor pops and compares on every DUT event.
module tb_pasta_job_scheduler;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [1:0]  req_i;
    logic [15:0] nblk_i;
    logic [63:0] ptxt_base_i;
    logic [1:0]  ack_o;
    logic [1:0]  done_o;
    logic        core_start_o;
    logic        core_busy_i;
    logic        core_finish_i;
    logic [63:0] blk_ctr_o;
    logic [31:0] ptxt_addr_o;
    logic        owner_o;
    logic        busy_o;
    logic        timeout_o;

    always #5 clk = ~clk;

    pasta_job_scheduler dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .req_i         (req_i),
        .nblk_i        (nblk_i),
        .ptxt_base_i   (ptxt_base_i),
        .ack_o         (ack_o),
        .done_o        (done_o),
        .core_start_o  (core_start_o),
        .core_busy_i   (core_busy_i),
        .core_finish_i (core_finish_i),
        .blk_ctr_o     (blk_ctr_o),
        .ptxt_addr_o   (ptxt_addr_o),
        .owner_o       (owner_o),
        .busy_o        (busy_o),
        .timeout_o     (timeout_o)
    );

    typedef struct packed {
        logic        owner;
        logic [63:0] ctr;
        logic [31:0] addr;
    } blk_t;

    typedef struct packed {
        logic [1:0] done;
        logic       busy;
    } done_t;

    logic [1:0] exp_ack_q[$];
    blk_t       exp_blk_q[$];
    done_t      exp_done_q[$];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_events = 0;
    logic model_last = 1'b1;

    // core emulation controls
    bit   core_en = 1'b1;
    bit   stray_en = 1'b0;
    int   hold_busy = 0;
    int   lat_fixed = 0;
    bit   inject_finish = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic fail(input string name, input logic [63:0] got);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %0h required nothing here", name, got);
    endtask

    // busy level the DUT saw at the last rising edge
    logic busy_at_edge = 1'b0;
    always @(posedge clk) busy_at_edge <= core_busy_i;

    // monitor: pop and compare on every DUT event
    initial begin
        logic [1:0] ea;
        blk_t       eb;
        done_t      ed;
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                if (ack_o != 2'b00) begin
                    if (exp_ack_q.size() == 0) fail("unexpected_ack", ack_o);
                    else begin
                        ea = exp_ack_q.pop_front();
                        chk("ack", ack_o, ea);
                        chk("owner_on_ack", owner_o, ea[1]);
                    end
                end
                if (core_start_o) begin
                    chk("start_while_busy", busy_at_edge, 0);
                    if (exp_blk_q.size() == 0) fail("unexpected_start", blk_ctr_o);
                    else begin
                        eb = exp_blk_q.pop_front();
                        chk("blk_owner", owner_o, eb.owner);
                        chk("blk_ctr", blk_ctr_o, eb.ctr);
                        chk("ptxt_addr", ptxt_addr_o, eb.addr);
                    end
                end
                if (done_o != 2'b00) begin
                    done_events++;
                    if (exp_done_q.size() == 0) fail("unexpected_done", done_o);
                    else begin
                        ed = exp_done_q.pop_front();
                        chk("done", done_o, ed.done);
                        chk("busy_at_done", busy_o, ed.busy);
                    end
                end
`ifndef PASTA_SCHED_TIMEOUT_EN
                if (timeout_o) fail("timeout_without_watchdog", timeout_o);
`endif
            end
        end
    end

    // permutation core model: optional busy phases, latency, stray finishes
    initial begin
        bit outstanding = 1'b0;
        int lat = 0;
        core_busy_i   = 1'b0;
        core_finish_i = 1'b0;
        forever begin
            @(negedge clk);
            core_finish_i = 1'b0;
            if (!core_en) begin
                outstanding   = 1'b0;
                core_busy_i   = 1'b0;
                core_finish_i = inject_finish;
                inject_finish = 1'b0;
            end else if (core_start_o) begin
                outstanding = 1'b1;
                core_busy_i = 1'b0;
                lat = (lat_fixed > 0) ? lat_fixed - 1 : int'($urandom_range(0, 6));
            end else if (outstanding) begin
                if (lat == 0) begin
                    core_finish_i = 1'b1;
                    outstanding   = 1'b0;
                end else begin
                    lat--;
                end
            end else if (hold_busy > 0) begin
                core_busy_i = 1'b1;
                hold_busy--;
                if (stray_en) core_finish_i = 1'($urandom_range(0, 1));
            end else begin
                core_busy_i = ($urandom_range(0, 2) == 0);
                if (stray_en) core_finish_i = ($urandom_range(0, 3) == 0);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1;
        exp_ack_q.delete();
        exp_blk_q.delete();
        exp_done_q.delete();
        model_last = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    // predict one job from the arbitration rules and push its expected events
    task automatic predict(input logic [1:0] req, input logic [7:0] n0, input logic [7:0] n1,
                           input logic [31:0] b0, input logic [31:0] b1, input bit with_done);
        logic        o;
        logic [7:0]  n;
        logic [31:0] b;
        o = (req == 2'b01) ? 1'b0 : (req == 2'b10) ? 1'b1 : ~model_last;
        n = o ? n1 : n0;
        b = o ? b1 : b0;
        exp_ack_q.push_back(2'b01 << o);
        for (int k = 0; k < int'(n); k++)
            exp_blk_q.push_back('{o, 64'(k), b + 32'(68 * k)});
        if (with_done) begin
            exp_done_q.push_back('{2'b01 << o, (n == 8'd0)});
            model_last = o;
        end
    endtask

    task automatic wait_ack();
        int t = 0;
        while (ack_o == 2'b00 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (ack_o == 2'b00) fail("ack_wait_expired", t);
    endtask

    task automatic wait_start();
        int t = 0;
        while (!core_start_o && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!core_start_o) fail("start_wait_expired", t);
    endtask

    task automatic issue(input logic [1:0] req, input logic [7:0] n0, input logic [7:0] n1,
                         input logic [31:0] b0, input logic [31:0] b1, input bit hold_req);
        int  t = 0;
        bit  zero;
        zero = ((req == 2'b10) || (req == 2'b11 && model_last == 1'b0)) ? (n1 == 8'd0) : (n0 == 8'd0);
        predict(req, n0, n1, b0, b1, 1'b1);
        @(negedge clk);
        nblk_i      = {n1, n0};
        ptxt_base_i = {b1, b0};
        req_i       = req;
        wait_ack();
        if (!hold_req) req_i = 2'b00;
        while (done_o == 2'b00 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (done_o == 2'b00) fail("done_wait_expired", t);
        if (zero && !hold_req) begin
            @(negedge clk);
            chk("idle_after_zero_len", busy_o, 0);
        end
    endtask

    initial begin
        int d0;
        rst_i         = 1'b1;
        req_i         = 2'b00;
        nblk_i        = 16'd0;
        ptxt_base_i   = 64'd0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_ack", ack_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_start", core_start_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_owner", owner_o, 0);
        chk("rst_ctr", blk_ctr_o, 0);
        chk("rst_addr", ptxt_addr_o, 0);
        chk("rst_timeout", timeout_o, 0);
        rst_i = 1'b0;

        // single three-block job, core finishes 20 cycles after each start
        lat_fixed = 20;
        issue(2'b01, 8'd3, 8'd0, 32'h1000, 32'h0, 1'b0);
        chk("busy_after_job", busy_o, 0);
        lat_fixed = 0;

        // contention from reset: both held, one block each
        do_reset();
        for (int i = 0; i < 4; i++)
            issue(2'b11, 8'd1, 8'd1, 32'h2000, 32'h8000, 1'b1);
        req_i = 2'b00;

        // zero-length job on requester 1
        issue(2'b10, 8'd5, 8'd0, 32'h0, 32'h3000, 1'b0);

        // core busy for 5 cycles in START, stray finishes outside WAIT
        hold_busy = 5;
        stray_en  = 1'b1;
        issue(2'b01, 8'd2, 8'd0, 32'h4000, 32'h0, 1'b0);

        // randomized jobs, including address wrap near 2^32
        for (int i = 0; i < 40; i++) begin
            logic [31:0] b0, b1;
            b0 = $urandom;
            b1 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FF80 : $urandom;
            issue(2'($urandom_range(1, 3)), 8'($urandom_range(0, 4)), 8'($urandom_range(0, 4)),
                  b0, b1, 1'b0);
        end
        stray_en = 1'b0;

        // reset while waiting on the core; late finish must not complete anything
        core_en = 1'b0;
        @(negedge clk);
        predict(2'b10, 8'd2, 8'd2, 32'h0, 32'h5000, 1'b0);
        nblk_i      = {8'd2, 8'd2};
        ptxt_base_i = {32'h5000, 32'h0};
        req_i       = 2'b10;
        wait_ack();
        req_i = 2'b00;
        wait_start();
        d0 = done_events;
        @(posedge clk);
        #2 rst_i = 1'b1;
        exp_ack_q.delete();
        exp_blk_q.delete();
        exp_done_q.delete();
        model_last = 1'b1;
        #1;
        chk("midrst_ack", ack_o, 0);
        chk("midrst_done", done_o, 0);
        chk("midrst_start", core_start_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_owner", owner_o, 0);
        chk("midrst_ctr", blk_ctr_o, 0);
        chk("midrst_addr", ptxt_addr_o, 0);
        @(negedge clk);
        rst_i = 1'b0;
        inject_finish = 1'b1;
        repeat (6) @(negedge clk);
        chk("late_finish_done_count", done_events, d0);
        chk("late_finish_busy", busy_o, 0);
        core_en = 1'b1;

        // first tie after reset goes to requester 0
        issue(2'b11, 8'd1, 8'd1, 32'h6000, 32'h7000, 1'b0);

        // core never finishes
        core_en = 1'b0;
        @(negedge clk);
`ifdef PASTA_SCHED_TIMEOUT_EN
        predict(2'b01, 8'd1, 8'd0, 32'h9000, 32'h0, 1'b1);
`else
        predict(2'b01, 8'd1, 8'd0, 32'h9000, 32'h0, 1'b0);
`endif
        nblk_i      = {8'd0, 8'd1};
        ptxt_base_i = {32'h0, 32'h9000};
        req_i       = 2'b01;
        wait_ack();
        req_i = 2'b00;
        wait_start();
`ifdef PASTA_SCHED_TIMEOUT_EN
        begin
            int t = 0;
            while (!timeout_o && t < 1200) begin
                @(negedge clk);
                t++;
            end
            chk("timeout_latency", t, 1024);
            chk("timeout_done", done_o, 2'b01);
            @(negedge clk);
            chk("timeout_one_cycle", timeout_o, 0);
        end
`else
        repeat (1100) @(negedge clk);
        chk("hang_busy", busy_o, 1);
        chk("hang_timeout", timeout_o, 0);
        do_reset();
`endif
        core_en = 1'b1;
        repeat (3) @(negedge clk);

        chk("queues_drained", exp_ack_q.size() + exp_blk_q.size() + exp_done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
